// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the accumulator bank and the distance solver.
//   - calc_state_e : control states of calc_accum_bank
//   - CALC_*       : default field widths and bank geometry
//   - sat_sum_w    : width of the internal adder of a saturating field
package calc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } calc_state_e;

    localparam int CALC_NBINS      = 4;
    localparam int CALC_G_W        = 3;
    localparam int CALC_G2_W       = 6;
    localparam int CALC_FG_W       = 6;
    localparam int CALC_GSUM_W     = 11;
    localparam int CALC_G2SUM_W    = 14;
    localparam int CALC_FGSUM_W    = 14;
    localparam int CALC_PLACE_W    = 8;
    localparam int CALC_PLACE_STEP = 16;
    localparam int CALC_DROP_W     = 8;

    // The adder is one bit wider than the field; its carry-out flags overflow.
    function automatic int sat_sum_w(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/sat_acc.sv
// sat_acc: one saturating accumulator field with a sticky saturation flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of value and flag (wins over en)
//   en         : add din into the field this cycle
//   din        : unsigned addend (IN_W bits, IN_W <= W)
//   acc, sat   : registered value and sticky saturation flag
//   acc_nxt, sat_nxt : the values that will be registered at the next edge
module sat_acc
    import calc_pkg::*;
#(
    parameter int W    = CALC_GSUM_W,
    parameter int IN_W = CALC_G_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] din,
    output logic [W-1:0]    acc,
    output logic            sat,
    output logic [W-1:0]    acc_nxt,
    output logic            sat_nxt
);
    localparam int SUM_W = sat_sum_w(W);

    logic [SUM_W-1:0] sum_s;
    logic [W-1:0]     acc_r;
    logic             sat_r;

    // Next-value logic: width-extended add, clamp to all-ones on carry-out.
    always_comb begin
        sum_s   = {1'b0, acc_r} + SUM_W'(din);
        acc_nxt = acc_r;
        sat_nxt = sat_r;
        if (clr) begin
            acc_nxt = {W{1'b0}};
            sat_nxt = 1'b0;
        end else if (en) begin
            if (sum_s[W]) begin
                acc_nxt = {W{1'b1}};
                sat_nxt = 1'b1;
            end else begin
                acc_nxt = sum_s[W-1:0];
                sat_nxt = sat_r;
            end
        end else begin
            acc_nxt = acc_r;
            sat_nxt = sat_r;
        end
    end

    // Field register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {W{1'b0}};
            sat_r <= 1'b0;
        end else begin
            acc_r <= acc_nxt;
            sat_r <= sat_nxt;
        end
    end

    assign acc = acc_r;
    assign sat = sat_r;

endmodule

// File: rtl/calc_accum_bank.sv
// calc_accum_bank: NBINS-bin saturating g / g^2 / f*g accumulator with
// a valid/ready readout stream tagged by place.
//   start, startplace      : clear bank, latch place of bin 0, begin accumulating
//   sample_valid, gdata, g2data, fgdata : per-sample inputs
//   bin_adv                : advance to next bin (last bin -> FULL)
//   flush                  : begin readout of all bins
//   out_valid/out_ready    : result handshake; gsum, g2sum, fgsum, place,
//                            sat, out_last describe the current bin
//   busy                   : not idle
//   drop_cnt               : samples discarded since start (saturating)
module calc_accum_bank
    import calc_pkg::*;
#(
    parameter int NBINS      = CALC_NBINS,
    parameter int G_W        = CALC_G_W,
    parameter int G2_W       = CALC_G2_W,
    parameter int FG_W       = CALC_FG_W,
    parameter int GSUM_W     = CALC_GSUM_W,
    parameter int G2SUM_W    = CALC_G2SUM_W,
    parameter int FGSUM_W    = CALC_FGSUM_W,
    parameter int PLACE_W    = CALC_PLACE_W,
    parameter int PLACE_STEP = CALC_PLACE_STEP,
    parameter int DROP_W     = CALC_DROP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PLACE_W-1:0] startplace,
    input  logic               sample_valid,
    input  logic [G_W-1:0]     gdata,
    input  logic [G2_W-1:0]    g2data,
    input  logic [FG_W-1:0]    fgdata,
    input  logic               bin_adv,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [GSUM_W-1:0]  gsum,
    output logic [G2SUM_W-1:0] g2sum,
    output logic [FGSUM_W-1:0] fgsum,
    output logic [PLACE_W-1:0] place,
    output logic               sat,
    output logic               out_last,
    output logic               busy,
    output logic [DROP_W-1:0]  drop_cnt
);
    localparam int PTR_W = $clog2(NBINS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NBINS - 1);

    calc_state_e        state_r;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   idx_r;
    logic [PTR_W-1:0]   tgt_s;
    logic [PTR_W-1:0]   nxt_idx_s;
    logic               last_adv_s;
    logic               accum_s;
    logic               drop_s;
    logic               enter_drain_s;
    logic [PLACE_W-1:0] base_r;
    logic [PLACE_W-1:0] place_r;
    logic [DROP_W-1:0]  drop_cnt_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               sat_r;
    logic               busy_r;
    logic [GSUM_W-1:0]  gsum_r;
    logic [G2SUM_W-1:0] g2sum_r;
    logic [FGSUM_W-1:0] fgsum_r;

    logic [GSUM_W-1:0]  g_acc_s  [NBINS];
    logic [GSUM_W-1:0]  g_nxt_s  [NBINS];
    logic [G2SUM_W-1:0] g2_acc_s [NBINS];
    logic [G2SUM_W-1:0] g2_nxt_s [NBINS];
    logic [FGSUM_W-1:0] fg_acc_s [NBINS];
    logic [FGSUM_W-1:0] fg_nxt_s [NBINS];
    logic [NBINS-1:0]   en_s;
    logic [NBINS-1:0]   g_sat_s,  g2_sat_s,  fg_sat_s;
    logic [NBINS-1:0]   g_satn_s, g2_satn_s, fg_satn_s;
    logic [NBINS-1:0]   bin_sat_s;
    logic [NBINS-1:0]   bin_satn_s;

    // Bin targeted by this cycle's sample: a simultaneous bin_adv moves the
    // sample into the next bin; advancing past the last bin leaves no target.
    always_comb begin
        tgt_s      = ptr_r;
        last_adv_s = 1'b0;
        if ((state_r == ST_ACCUM) && bin_adv) begin
            if (ptr_r == LAST_PTR) begin
                last_adv_s = 1'b1;
            end else begin
                tgt_s = ptr_r + PTR_W'(1);
            end
        end else begin
            tgt_s = ptr_r;
        end
    end

    assign accum_s       = !start && sample_valid && (state_r == ST_ACCUM) && !last_adv_s;
    assign drop_s        = !start && sample_valid && ((state_r == ST_FULL) || last_adv_s);
    assign enter_drain_s = !start && flush && ((state_r == ST_ACCUM) || (state_r == ST_FULL));
    assign nxt_idx_s     = idx_r + PTR_W'(1);
    assign bin_sat_s     = g_sat_s | g2_sat_s | fg_sat_s;
    assign bin_satn_s    = g_satn_s | g2_satn_s | fg_satn_s;

    for (genvar b = 0; b < NBINS; b++) begin : g_bin
        assign en_s[b] = accum_s && (tgt_s == PTR_W'(b));

        sat_acc #(.W(GSUM_W), .IN_W(G_W)) u_g (
            .clk(clk), .rst_n(rst_n), .clr(start), .en(en_s[b]), .din(gdata),
            .acc(g_acc_s[b]), .sat(g_sat_s[b]),
            .acc_nxt(g_nxt_s[b]), .sat_nxt(g_satn_s[b])
        );
        sat_acc #(.W(G2SUM_W), .IN_W(G2_W)) u_g2 (
            .clk(clk), .rst_n(rst_n), .clr(start), .en(en_s[b]), .din(g2data),
            .acc(g2_acc_s[b]), .sat(g2_sat_s[b]),
            .acc_nxt(g2_nxt_s[b]), .sat_nxt(g2_satn_s[b])
        );
        sat_acc #(.W(FGSUM_W), .IN_W(FG_W)) u_fg (
            .clk(clk), .rst_n(rst_n), .clr(start), .en(en_s[b]), .din(fgdata),
            .acc(fg_acc_s[b]), .sat(fg_sat_s[b]),
            .acc_nxt(fg_nxt_s[b]), .sat_nxt(fg_satn_s[b])
        );
    end

    // Dropped-sample counter, saturating at all-ones, cleared by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (start) begin
            drop_cnt_r <= {DROP_W{1'b0}};
        end else if (drop_s && (drop_cnt_r != {DROP_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + DROP_W'(1);
        end
    end

    // Control FSM and registered result port.
    // Bin 0 is loaded from its next value on flush so that a sample arriving
    // in the flush cycle is included; during DRAIN the bins are frozen, so
    // later bins are read from their registered values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {PTR_W{1'b0}};
            idx_r       <= {PTR_W{1'b0}};
            base_r      <= {PLACE_W{1'b0}};
            place_r     <= {PLACE_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            sat_r       <= 1'b0;
            busy_r      <= 1'b0;
            gsum_r      <= {GSUM_W{1'b0}};
            g2sum_r     <= {G2SUM_W{1'b0}};
            fgsum_r     <= {FGSUM_W{1'b0}};
        end else if (start) begin
            state_r     <= ST_ACCUM;
            ptr_r       <= {PTR_W{1'b0}};
            idx_r       <= {PTR_W{1'b0}};
            base_r      <= startplace;
            place_r     <= {PLACE_W{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            sat_r       <= 1'b0;
            busy_r      <= 1'b1;
            gsum_r      <= {GSUM_W{1'b0}};
            g2sum_r     <= {G2SUM_W{1'b0}};
            fgsum_r     <= {FGSUM_W{1'b0}};
        end else if (enter_drain_s) begin
            state_r     <= ST_DRAIN;
            idx_r       <= {PTR_W{1'b0}};
            out_valid_r <= 1'b1;
            out_last_r  <= (LAST_PTR == {PTR_W{1'b0}});
            gsum_r      <= g_nxt_s[0];
            g2sum_r     <= g2_nxt_s[0];
            fgsum_r     <= fg_nxt_s[0];
            sat_r       <= bin_satn_s[0];
            place_r     <= base_r;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (last_adv_s) begin
                        state_r <= ST_FULL;
                    end else begin
                        ptr_r <= tgt_s;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid_r && out_ready) begin
                        if (out_last_r) begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                        end else begin
                            idx_r      <= nxt_idx_s;
                            gsum_r     <= g_acc_s[nxt_idx_s];
                            g2sum_r    <= g2_acc_s[nxt_idx_s];
                            fgsum_r    <= fg_acc_s[nxt_idx_s];
                            sat_r      <= bin_sat_s[nxt_idx_s];
                            place_r    <= place_r + PLACE_W'(PLACE_STEP);
                            out_last_r <= (nxt_idx_s == LAST_PTR);
                        end
                    end
                end
                ST_IDLE, ST_FULL: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign gsum      = gsum_r;
    assign g2sum     = g2sum_r;
    assign fgsum     = fgsum_r;
    assign place     = place_r;
    assign sat       = sat_r;
    assign busy      = busy_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_calc_accum_bank.sv
// Self-checking bench for calc_accum_bank: directed scenarios plus random
// episodes, all checked against a bin-array reference model.
module tb_calc_accum_bank;
    localparam int NBINS = 4, G_W = 3, G2_W = 6, FG_W = 6;
    localparam int GSUM_W = 11, G2SUM_W = 14, FGSUM_W = 14;
    localparam int PLACE_W = 8, PLACE_STEP = 16, DROP_W = 8;
    localparam int M_IDLE = 0, M_ACC = 1, M_FULL = 2, M_DRAIN = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [PLACE_W-1:0] startplace = '0;
    logic               sample_valid = 1'b0;
    logic [G_W-1:0]     gdata = '0;
    logic [G2_W-1:0]    g2data = '0;
    logic [FG_W-1:0]    fgdata = '0;
    logic               bin_adv = 1'b0;
    logic               flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [GSUM_W-1:0]  gsum;
    logic [G2SUM_W-1:0] g2sum;
    logic [FGSUM_W-1:0] fgsum;
    logic [PLACE_W-1:0] place;
    logic               sat;
    logic               out_last;
    logic               busy;
    logic [DROP_W-1:0]  drop_cnt;

    always #5 clk = ~clk;

    calc_accum_bank #(
        .NBINS(NBINS), .G_W(G_W), .G2_W(G2_W), .FG_W(FG_W),
        .GSUM_W(GSUM_W), .G2SUM_W(G2SUM_W), .FGSUM_W(FGSUM_W),
        .PLACE_W(PLACE_W), .PLACE_STEP(PLACE_STEP), .DROP_W(DROP_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .startplace(startplace),
        .sample_valid(sample_valid), .gdata(gdata), .g2data(g2data), .fgdata(fgdata),
        .bin_adv(bin_adv), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .gsum(gsum), .g2sum(g2sum), .fgsum(fgsum), .place(place), .sat(sat),
        .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: plain integer bins and a queue of pending results.
    typedef struct {
        int g; int g2; int fg; int pl; bit st; bit last;
    } res_t;

    int   m_g [NBINS];
    int   m_g2[NBINS];
    int   m_fg[NBINS];
    bit   m_sat[NBINS];
    int   m_ptr, m_mode, m_base, m_drop;
    res_t q[$];
    int   dut_xfers;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_add(input int a, input int b, input int w);
        int mx = (1 << w) - 1;
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NBINS; i++) begin
            m_g[i] = 0; m_g2[i] = 0; m_fg[i] = 0; m_sat[i] = 1'b0;
        end
        m_ptr = 0;
        m_drop = 0;
        q.delete();
    endtask

    task automatic model_add(input int b, input int g, input int g2, input int fg);
        if (m_g[b] + g > (1 << GSUM_W) - 1)    m_sat[b] = 1'b1;
        if (m_g2[b] + g2 > (1 << G2SUM_W) - 1) m_sat[b] = 1'b1;
        if (m_fg[b] + fg > (1 << FGSUM_W) - 1) m_sat[b] = 1'b1;
        m_g[b]  = clamp_add(m_g[b], g, GSUM_W);
        m_g2[b] = clamp_add(m_g2[b], g2, G2SUM_W);
        m_fg[b] = clamp_add(m_fg[b], fg, FGSUM_W);
    endtask

    task automatic model_flush();
        res_t r;
        for (int i = 0; i < NBINS; i++) begin
            r.g = m_g[i]; r.g2 = m_g2[i]; r.fg = m_fg[i];
            r.pl = (m_base + i * PLACE_STEP) % (1 << PLACE_W);
            r.st = m_sat[i];
            r.last = (i == NBINS - 1);
            q.push_back(r);
        end
        m_mode = M_DRAIN;
    endtask

    // One clock: inputs are captured before the edge, the model advances
    // for that edge, outputs are then observed 1 time unit later.
    task automatic cyc();
        bit st = start, sv = sample_valid, adv = bin_adv, fl = flush, rdy = out_ready;
        int g = int'(gdata), g2 = int'(g2data), fg = int'(fgdata), sp = int'(startplace);
        int tgt;
        bit la;
        if (out_valid && out_ready) dut_xfers++;
        @(posedge clk);
        if (st) begin
            model_clear();
            m_base = sp;
            m_mode = M_ACC;
        end else begin
            case (m_mode)
                M_ACC: begin
                    tgt = m_ptr; la = 1'b0;
                    if (adv) begin
                        if (m_ptr == NBINS - 1) la = 1'b1;
                        else tgt = m_ptr + 1;
                    end
                    if (sv) begin
                        if (la) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
                        else model_add(tgt, g, g2, fg);
                    end
                    if (fl) model_flush();
                    else if (la) m_mode = M_FULL;
                    else m_ptr = tgt;
                end
                M_FULL: begin
                    if (sv) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
                    if (fl) model_flush();
                end
                M_DRAIN: begin
                    if (rdy) begin
                        void'(q.pop_front());
                        if (q.size() == 0) m_mode = M_IDLE;
                    end
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(m_mode == M_DRAIN));
        chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (m_mode == M_DRAIN) begin
            chk("gsum", 32'(gsum), 32'(q[0].g));
            chk("g2sum", 32'(g2sum), 32'(q[0].g2));
            chk("fgsum", 32'(fgsum), 32'(q[0].fg));
            chk("place", 32'(place), 32'(q[0].pl));
            chk("sat", 32'(sat), 32'(q[0].st));
            chk("out_last", 32'(out_last), 32'(q[0].last));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_gsum"}, 32'(gsum), 32'd0);
        chk({tag, "_g2sum"}, 32'(g2sum), 32'd0);
        chk({tag, "_fgsum"}, 32'(fgsum), 32'd0);
        chk({tag, "_place"}, 32'(place), 32'd0);
        chk({tag, "_sat"}, 32'(sat), 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
    endtask

    task automatic drive(input bit st, input bit sv, input int g, input int g2,
                         input int fg, input bit adv, input bit fl);
        start = st; sample_valid = sv; bin_adv = adv; flush = fl;
        gdata = G_W'(g); g2data = G2_W'(g2); fgdata = FG_W'(fg);
        cyc();
        check_outputs();
        start = 1'b0; sample_valid = 1'b0; bin_adv = 1'b0; flush = 1'b0;
    endtask

    // Drain with a ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
    task automatic drain(input int pat);
        dut_xfers = 0;
        for (int c = 0; c < 200 && m_mode == M_DRAIN; c++) begin
            case (pat)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            cyc();
            check_outputs();
        end
        out_ready = 1'b0;
        chk("drain_done", 32'(m_mode), 32'(M_IDLE));
        chk("xfers", 32'(dut_xfers), 32'(NBINS));
    endtask

    initial begin
        model_clear();
        m_mode = M_IDLE;
        m_base = 0;
        dut_xfers = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic fill
        startplace = 8'h20;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 2, 4, 6, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 7, 49, 35, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        drain(0);

        // Ignored in IDLE: sample, bin_adv and flush together
        drive(1'b0, 1'b1, 7, 63, 63, 1'b1, 1'b1);

        // Simultaneous advance and sample, then FULL with drop counter saturation
        startplace = 8'h05;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3, 9, 12, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 5, 25, 20, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 5, 25, 20, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        repeat (300) drive(1'b0, 1'b1, 1, 1, 1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1, 1, 1, 1'b0, 1'b1);
        drain(1);

        // Saturation in bin 0 only
        startplace = 8'h00;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (300) drive(1'b0, 1'b1, 7, 63, 63, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1, 2, 3, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4, 5, 6, 1'b0, 1'b1);
        drain(2);

        // Abort a drain after two transfers
        startplace = 8'h10;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (4) drive(1'b0, 1'b1, $urandom, $urandom, $urandom, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        drain(0);

        // Random episodes
        for (int ep = 0; ep < 6; ep++) begin
            startplace = PLACE_W'($urandom);
            drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
            for (int c = 0; c < 40; c++)
                drive(1'b0, ($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
                      ($urandom_range(0, 7) == 0), 1'b0);
            drive(1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3) == 0, 1'b1);
            drain(2);
        end

        // Asynchronous reset mid-ACCUM, released between clock edges
        startplace = 8'h44;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 6, 36, 30, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_clear();
        m_mode = M_IDLE;
        @(negedge clk);
        rst_n = 1'b1;

        // Restart with place wrap-around
        startplace = 8'hF0;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1, 1, 1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 2, 4, 2, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        drain(0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/calc_accum_bank.md
Name: calc_accum_bank

Overview:
- Parametrised, synchronous successor of the fixed four-bin g/g²/fg accumulator used in the double-eye distance datapath.
- Accumulates per-sample gdata, g2data and fgdata into NBINS window bins, selected by a bin pointer that advances on command.
- Drains the bin results over a valid/ready stream, each tagged with its place index, to the downstream distance solver.
- Adds saturating sums, per-bin overflow flags, flow-controlled readout and a sample-drop counter.

Parameters:
NBINS, 4, number of accumulation bins (2..16)
G_W, 3, width of gdata and fdata
G2_W, 6, width of g2data
FG_W, 6, width of fgdata
GSUM_W, 11, width of the gsum accumulator
G2SUM_W, 14, width of the g2sum accumulator
FGSUM_W, 14, width of the fgsum accumulator
PLACE_W, 8, width of startplace and place
PLACE_STEP, 16, place increment between consecutive bins
DROP_W, 8, width of the dropped-sample counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear all bins, pointer to bin 0, enter ACCUM
startplace  in  PLACE_W  place of bin 0; sampled on start
sample_valid  in  1  gdata/g2data/fgdata valid this cycle
gdata  in  G_W  unsigned g sample
g2data  in  G2_W  unsigned g² sample
fgdata  in  FG_W  unsigned f·g sample
bin_adv  in  1  advance bin pointer
flush  in  1  begin readout
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
gsum  out  GSUM_W  bin g sum
g2sum  out  G2SUM_W  bin g² sum
fgsum  out  FGSUM_W  bin f·g sum
place  out  PLACE_W  startplace + idx·PLACE_STEP, modulo 2^PLACE_W
sat  out  1  the bin saturated in at least one of its three sums
out_last  out  1  asserted with the final bin
busy  out  1  state ≠ IDLE
drop_cnt  out  DROP_W  samples discarded since start; saturates at all-ones

Behaviour:
- Reset: state IDLE; every bin, pointer, drop_cnt, out_valid, out_last, sat, gsum, g2sum, fgsum and place are 0; busy is 0.
- States: IDLE, ACCUM, FULL, DRAIN.
- start (any state, highest priority): clear bins, sat flags and drop_cnt; ptr=0; latch startplace; go ACCUM. An in-progress DRAIN is aborted and out_valid drops the next cycle.
- ACCUM, sample_valid: bin[ptr] += each sample; update visible the next cycle. The adder is width-extended by one bit; if the sum exceeds the field maximum, the field holds all-ones and the bin sat flag is set (sticky until start).
- ACCUM, bin_adv: when ptr<NBINS-1, ptr++; when ptr==NBINS-1, go FULL.
- bin_adv together with sample_valid: the sample goes to the new bin (ptr+1). From the last bin, the sample is dropped and counted.
- FULL: samples are dropped and drop_cnt increments; bin_adv is ignored.
- sample_valid in IDLE or DRAIN: ignored, not counted.
- flush in ACCUM or FULL: go DRAIN, idx=0. A sample_valid in the same cycle is still accumulated first. flush in IDLE or DRAIN is ignored.
- DRAIN: outputs are registered. out_valid rises the cycle after flush. Each output holds stable until out_valid&&out_ready.
- On a transfer, idx++. The transfer with out_last=1 (idx==NBINS-1) returns to IDLE with out_valid=0 the next cycle. Bin contents persist until the next start.
- Throughput in DRAIN: one result per cycle while out_ready stays high.

Decomposition:
- Package calc_pkg: state enum, saturating-add width rule and default width constants shared with the distance solver.
- Sub-module sat_acc (parametrised width W): one saturating accumulator field with sat output, instantiated 3×NBINS.

Test Plan:
- Basic fill: start, startplace=8'h20; 3 samples (g=2,g2=4,fg=6) into bin 0, bin_adv, 1 sample (g=7,g2=49,fg=35) into bin 1, flush, out_ready=1 -> 4 results: bin0 6/12/18 place 0x20; bin1 7/49/35 place 0x30; bins 2,3 zero at places 0x40,0x50; out_last on the 4th result; then IDLE.
- Saturation: GSUM_W=4, g=7 on 3 consecutive cycles -> gsum=15, sat=1 for that bin only.
- Simultaneous adv+sample: bin_adv with g=5 at ptr=0 -> bin1 gsum=5, bin0 unchanged. At ptr=3 the same stimulus -> FULL, drop_cnt=1.
- Backpressure: out_ready toggled 1,0,0,1,... -> each result held stable while ready is low; exactly NBINS transfers total; no duplicates or skips.
- Abort: start during DRAIN after 2 transfers -> out_valid=0 the next cycle, bins cleared, state ACCUM, drop_cnt=0.
- Async reset: rst_n low mid-ACCUM, deasserted between clock edges -> all outputs 0 immediately; the next start behaves normally; place wraps modulo 256 when startplace=8'hF0 (bin1 place 0x00).
